decode_stage: RTL and testbench

- Registered, handshaked instruction decode stage. Sits between the instruction fetch buffer and the execute stage.
- Decodes all eight optypes into register addresses, ALU op, immediate and control flags, with field widths set by parameters.
- Holds one decoded instruction in an output register using a valid/ready handshake.
- Tracks in-flight register writes in a scoreboard and stalls read-after-write hazards until writeback.

---
 rtl/decode_stage.sv | 192 +++++++++++++++++++
 tb/tb_decode_stage.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// ============================================================================
// Module   : decode_stage
// Purpose  : Registered, handshaked instruction decode stage with a register
//            write scoreboard that stalls read-after-write hazards until the
//            matching writeback arrives.
// Options  : DECODE_PERF_CNT_EN adds a saturating 32-bit hazard stall counter
//            output (stall_cnt).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_stage #(
  parameter int INSTR_W    = 16,
  parameter int OPTYPE_W   = 3,
  parameter int REG_ADDR_W = 3,
  parameter int VALUE_W    = 16,
  parameter int ALU_OP_W   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INSTR_W-1:0]    instr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REG_ADDR_W-1:0] rs1,
  output logic [REG_ADDR_W-1:0] rs2,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [ALU_OP_W-1:0]   alu_op,
  output logic [VALUE_W-1:0]    imm,
  output logic                  reg_write,
  output logic                  print_value,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  flush,
  output logic                  busy
`ifdef DECODE_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  localparam int NUM_REGS = 2**REG_ADDR_W;
  localparam int RD_END   = OPTYPE_W + REG_ADDR_W;
  localparam int RS1_END  = RD_END + REG_ADDR_W;
  localparam int RS2_END  = RS1_END + REG_ADDR_W;

  localparam logic [ALU_OP_W-1:0] e_ALU_noop = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] e_ALU_add  = ALU_OP_W'(1);

  localparam logic [OPTYPE_W-1:0] c_op_p = OPTYPE_W'(0);
  localparam logic [OPTYPE_W-1:0] c_op_r = OPTYPE_W'(1);
  localparam logic [OPTYPE_W-1:0] c_op_i = OPTYPE_W'(2);
  localparam logic [OPTYPE_W-1:0] c_op_s = OPTYPE_W'(3);
  localparam logic [OPTYPE_W-1:0] c_op_b = OPTYPE_W'(4);
  localparam logic [OPTYPE_W-1:0] c_op_u = OPTYPE_W'(5);
  localparam logic [OPTYPE_W-1:0] c_op_j = OPTYPE_W'(6);
  localparam logic [OPTYPE_W-1:0] c_op_a = OPTYPE_W'(7);

  // Raw instruction fields
  logic [OPTYPE_W-1:0]       w_optype;
  logic [REG_ADDR_W-1:0]     w_f_rd, w_f_rs1, w_f_rs2;
  logic                      w_fn3_msb;
  logic [INSTR_W-4-RS1_END:0] w_iimm_raw;
  logic [VALUE_W-1:0]        w_iimm, w_pimm;

  assign w_optype   = instr[OPTYPE_W-1:0];
  assign w_f_rd     = instr[RD_END-1:OPTYPE_W];
  assign w_f_rs1    = instr[RS1_END-1:RD_END];
  assign w_f_rs2    = instr[RS2_END-1:RS1_END];
  assign w_fn3_msb  = instr[INSTR_W-1];
  assign w_iimm_raw = instr[INSTR_W-4:RS1_END];
  // fn3[2] selects an unsigned immediate; otherwise the field is signed
  assign w_iimm     = w_fn3_msb ? VALUE_W'(w_iimm_raw)
                                : VALUE_W'($signed(w_iimm_raw));
  assign w_pimm     = VALUE_W'(instr[INSTR_W-1:OPTYPE_W]);

  // Decoded bundle
  logic [REG_ADDR_W-1:0] w_dec_rd, w_dec_rs1, w_dec_rs2;
  logic [ALU_OP_W-1:0]   w_dec_alu;
  logic [VALUE_W-1:0]    w_dec_imm;
  logic                  w_dec_rw, w_dec_pv;

  // Optype decode: unused fields are forced to zero so hazard checks on them are harmless
  always_comb begin
    w_dec_rd  = '0;
    w_dec_rs1 = '0;
    w_dec_rs2 = '0;
    w_dec_imm = '0;
    w_dec_alu = e_ALU_noop;
    w_dec_rw  = 1'b0;
    w_dec_pv  = 1'b0;
    case (w_optype)
      c_op_r: begin
        w_dec_rw = 1'b1; w_dec_rd = w_f_rd; w_dec_rs1 = w_f_rs1;
        w_dec_rs2 = w_f_rs2; w_dec_alu = e_ALU_add;
      end
      c_op_i: begin
        w_dec_rw = 1'b1; w_dec_rd = w_f_rd; w_dec_rs1 = w_f_rs1;
        w_dec_imm = w_iimm; w_dec_alu = e_ALU_add;
      end
      c_op_s, c_op_b: begin
        w_dec_rs1 = w_f_rs1; w_dec_rs2 = w_f_rs2;
      end
      c_op_u: begin
        w_dec_rw = 1'b1; w_dec_rd = w_f_rd; w_dec_alu = e_ALU_add;
      end
      c_op_j: begin
        w_dec_rw = 1'b1; w_dec_rd = w_f_rd;
      end
      c_op_a: begin
        w_dec_rs1 = w_f_rs1; w_dec_alu = e_ALU_add; w_dec_pv = 1'b1;
      end
      c_op_p: begin
        w_dec_imm = w_pimm; w_dec_alu = e_ALU_add; w_dec_pv = 1'b1;
      end
      default: ;
    endcase
  end

  // Scoreboard and handshake
  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_pend_next;
  logic                w_hazard;
  logic                w_issue;

  assign w_hazard = r_pending[w_dec_rs1] | r_pending[w_dec_rs2];
  assign in_ready = (!out_valid | out_ready) & !w_hazard & !flush;
  assign w_issue  = in_valid & in_ready;
  assign busy     = |r_pending;

  // Next scoreboard: writeback clears first so a same-register issue set wins
  always_comb begin
    w_pend_next = r_pending;
    if (wb_valid) begin
      w_pend_next[wb_rd] = 1'b0;
    end
    if (w_issue && w_dec_rw && (w_dec_rd != '0)) begin
      w_pend_next[w_dec_rd] = 1'b1;
    end
  end

  // Scoreboard register; flush wipes all outstanding writes
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pend_next;
    end
  end

  // Output register: load on issue, hold under backpressure, drop when drained
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      rd          <= '0;
      rs1         <= '0;
      rs2         <= '0;
      imm         <= '0;
      alu_op      <= e_ALU_noop;
      reg_write   <= 1'b0;
      print_value <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (w_issue) begin
      out_valid   <= 1'b1;
      rd          <= w_dec_rd;
      rs1         <= w_dec_rs1;
      rs2         <= w_dec_rs2;
      imm         <= w_dec_imm;
      alu_op      <= w_dec_alu;
      reg_write   <= w_dec_rw;
      print_value <= w_dec_pv;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef DECODE_PERF_CNT_EN
  // Saturating count of cycles a presented instruction waits on a hazard
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (in_valid && w_hazard && !flush && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// ============================================================================
// Module   : tb_decode_stage
// Purpose  : Directed self-checking bench for decode_stage with a
//            behavioural reference model and per-cycle comparison.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode_stage;

  typedef struct packed {
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [15:0] imm;
    logic [1:0]  alu;
    logic        rw;
    logic        pv;
  } bundle_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] instr = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [2:0]  rs1, rs2, rd;
  logic [1:0]  alu_op;
  logic [15:0] imm;
  logic        reg_write, print_value;
  logic        wb_valid = 1'b0;
  logic [2:0]  wb_rd = '0;
  logic        flush = 1'b0;
  logic        busy;
`ifdef DECODE_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .out_valid(out_valid), .out_ready(out_ready),
    .rs1(rs1), .rs2(rs2), .rd(rd), .alu_op(alu_op), .imm(imm),
    .reg_write(reg_write), .print_value(print_value),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush), .busy(busy)
`ifdef DECODE_PERF_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Decode from the instruction table using plain arithmetic on the word.
  function automatic bundle_t model_dec(input logic [15:0] x);
    bundle_t b;
    int op, f_rd, f_rs1, f_rs2, ii, fn3;
    op    = int'(x) % 8;
    f_rd  = (int'(x) / 8) % 8;
    f_rs1 = (int'(x) / 64) % 8;
    f_rs2 = (int'(x) / 512) % 8;
    ii    = (int'(x) / 512) % 16;
    fn3   = int'(x) / 8192;
    b = '0;
    case (op)
      0: begin b.imm = 16'(int'(x) / 8); b.alu = 2'd1; b.pv = 1'b1; end
      1: begin b.rw = 1'b1; b.rd = 3'(f_rd); b.rs1 = 3'(f_rs1); b.rs2 = 3'(f_rs2); b.alu = 2'd1; end
      2: begin
        b.rw = 1'b1; b.rd = 3'(f_rd); b.rs1 = 3'(f_rs1); b.alu = 2'd1;
        if (fn3 >= 4 || ii < 8) b.imm = 16'(ii);
        else                    b.imm = 16'(ii + 65520);
      end
      3, 4: begin b.rs1 = 3'(f_rs1); b.rs2 = 3'(f_rs2); end
      5: begin b.rw = 1'b1; b.rd = 3'(f_rd); b.alu = 2'd1; end
      6: begin b.rw = 1'b1; b.rd = 3'(f_rd); end
      default: begin b.rs1 = 3'(f_rs1); b.alu = 2'd1; b.pv = 1'b1; end
    endcase
    return b;
  endfunction

  logic        m_init = 1'b0;
  logic        m_valid = 1'b0;
  bundle_t     m_b = '0;
  logic [7:0]  m_pend = '0;
  logic [31:0] m_stall = '0;

  function automatic logic m_hazard(input logic [7:0] p, input logic [15:0] x);
    bundle_t b;
    b = model_dec(x);
    return p[b.rs1] | p[b.rs2];
  endfunction

  function automatic logic m_ready(input logic v, input logic [7:0] p, input logic [15:0] x,
                                   input logic ordy, input logic fl);
    return (!v || ordy) && !m_hazard(p, x) && !fl;
  endfunction

  function automatic logic [7:0] m_next_pend(input logic [7:0] p, input logic iss,
                                             input logic [15:0] x, input logic wbv,
                                             input logic [2:0] wbr);
    logic [7:0] n;
    bundle_t b;
    b = model_dec(x);
    n = p;
    if (wbv) n[wbr] = 1'b0;
    if (iss && b.rw && b.rd != 3'd0) n[b.rd] = 1'b1;
    return n;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_init  <= 1'b1;
      m_valid <= 1'b0;
      m_b     <= '0;
      m_pend  <= '0;
      m_stall <= '0;
    end else begin
      if (in_valid && m_hazard(m_pend, instr) && !flush && m_stall != 32'hFFFF_FFFF)
        m_stall <= m_stall + 1;
      if (flush) begin
        m_valid <= 1'b0;
        m_pend  <= '0;
      end else begin
        m_pend <= m_next_pend(m_pend, in_valid && m_ready(m_valid, m_pend, instr, out_ready, flush),
                              instr, wb_valid, wb_rd);
        if (in_valid && m_ready(m_valid, m_pend, instr, out_ready, flush)) begin
          m_valid <= 1'b1;
          m_b     <= model_dec(instr);
        end else if (out_ready) begin
          m_valid <= 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, sampled on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (m_init) begin
        check("in_ready", {31'd0, in_ready}, {31'd0, m_ready(m_valid, m_pend, instr, out_ready, flush)});
        check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        check("busy", {31'd0, busy}, {31'd0, |m_pend});
`ifdef DECODE_PERF_CNT_EN
        check("stall_cnt", stall_cnt, m_stall);
`endif
        if (m_valid) begin
          check("rd", {29'd0, rd}, {29'd0, m_b.rd});
          check("rs1", {29'd0, rs1}, {29'd0, m_b.rs1});
          check("rs2", {29'd0, rs2}, {29'd0, m_b.rs2});
          check("imm", {16'd0, imm}, {16'd0, m_b.imm});
          check("alu_op", {30'd0, alu_op}, {30'd0, m_b.alu});
          check("reg_write", {31'd0, reg_write}, {31'd0, m_b.rw});
          check("print_value", {31'd0, print_value}, {31'd0, m_b.pv});
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input logic iv, input logic [15:0] ins, input logic ordy,
                       input logic wbv, input logic [2:0] wbr, input logic fl);
    in_valid = iv; instr = ins; out_ready = ordy; wb_valid = wbv; wb_rd = wbr; flush = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, 16'h0000, 1'b1, 1'b0, 3'd0, 1'b0);
    step(); step();
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst alu_op", {30'd0, alu_op}, 32'd0);
    check("rst imm", {16'd0, imm}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst in_ready", {31'd0, in_ready}, 32'd1);

    // R-type rd=2 rs1=1 rs2=3
    drive(1'b1, 16'h0651, 1'b1, 1'b0, 3'd0, 1'b0); step();
    check("R out_valid", {31'd0, out_valid}, 32'd1);
    check("R rd", {29'd0, rd}, 32'd2);
    check("R rs1", {29'd0, rs1}, 32'd1);
    check("R rs2", {29'd0, rs2}, 32'd3);
    check("R reg_write", {31'd0, reg_write}, 32'd1);
    check("R alu_op", {30'd0, alu_op}, 32'd1);
    check("R busy", {31'd0, busy}, 32'd1);

    // I-type, imm field 4'b1000: signed then unsigned
    drive(1'b1, 16'h101A, 1'b1, 1'b0, 3'd0, 1'b0); step();
    check("I signed imm", {16'd0, imm}, 32'h0000_FFF8);
    drive(1'b1, 16'h901A, 1'b1, 1'b0, 3'd0, 1'b0); step();
    check("I unsigned imm", {16'd0, imm}, 32'h0000_0008);

    // Retire writes to r2 and r3
    drive(1'b0, 16'h0000, 1'b1, 1'b1, 3'd2, 1'b0); step();
    check("drain out_valid", {31'd0, out_valid}, 32'd0);
    drive(1'b0, 16'h0000, 1'b1, 1'b1, 3'd3, 1'b0); step();
    check("wb busy", {31'd0, busy}, 32'd0);

    // RAW: writer rd=4, then A-type reader rs1=4
    drive(1'b1, 16'h0261, 1'b1, 1'b0, 3'd0, 1'b0); step();
    drive(1'b1, 16'h0107, 1'b1, 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("RAW stall in_ready", {31'd0, in_ready}, 32'd0);
      step();
    end
    drive(1'b1, 16'h0107, 1'b1, 1'b1, 3'd4, 1'b0); #1;
    check("wb no bypass", {31'd0, in_ready}, 32'd0);
    step();
    drive(1'b1, 16'h0107, 1'b1, 1'b0, 3'd0, 1'b0); #1;
    check("after wb in_ready", {31'd0, in_ready}, 32'd1);
    step();
    check("A rs1", {29'd0, rs1}, 32'd4);
    check("A print_value", {31'd0, print_value}, 32'd1);
    check("A reg_write", {31'd0, reg_write}, 32'd0);
`ifdef DECODE_PERF_CNT_EN
    check("stall count", stall_cnt, 32'd4);
`endif

    // Backpressure for 3 cycles, then U-type issues on release
    drive(1'b1, 16'h0035, 1'b0, 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp in_ready", {31'd0, in_ready}, 32'd0);
      step();
      check("bp hold rs1", {29'd0, rs1}, 32'd4);
      check("bp hold valid", {31'd0, out_valid}, 32'd1);
    end
    drive(1'b1, 16'h0035, 1'b1, 1'b0, 3'd0, 1'b0); #1;
    check("release in_ready", {31'd0, in_ready}, 32'd1);
    step();
    check("U rd", {29'd0, rd}, 32'd6);

    drive(1'b1, 16'h003E, 1'b1, 1'b0, 3'd0, 1'b0); step();
    check("J alu_op", {30'd0, alu_op}, 32'd0);
    check("J rd", {29'd0, rd}, 32'd7);
    drive(1'b1, 16'h0A7B, 1'b1, 1'b0, 3'd0, 1'b0); step();
    check("S rd", {29'd0, rd}, 32'd0);
    check("S rs2", {29'd0, rs2}, 32'd5);
    drive(1'b1, 16'h0A7C, 1'b1, 1'b0, 3'd0, 1'b0); step();
    check("B rs1", {29'd0, rs1}, 32'd1);

    // P-type payload 0x1ABC
    drive(1'b1, 16'hD5E0, 1'b1, 1'b0, 3'd0, 1'b0); step();
    check("P imm", {16'd0, imm}, 32'h0000_1ABC);
    check("P print_value", {31'd0, print_value}, 32'd1);
    check("P reg_write", {31'd0, reg_write}, 32'd0);

    // Flush with r5 pending and a held instruction
    drive(1'b1, 16'h0269, 1'b1, 1'b0, 3'd0, 1'b0); step();
    drive(1'b1, 16'h0249, 1'b1, 1'b0, 3'd0, 1'b1); #1;
    check("flush in_ready", {31'd0, in_ready}, 32'd0);
    step();
    check("flush out_valid", {31'd0, out_valid}, 32'd0);
    check("flush busy", {31'd0, busy}, 32'd0);
    drive(1'b0, 16'h0000, 1'b1, 1'b0, 3'd0, 1'b0); step();
    check("post flush valid", {31'd0, out_valid}, 32'd0);

    // Same-register set and clear: set wins
    drive(1'b1, 16'h0271, 1'b1, 1'b1, 3'd6, 1'b0); step();
    check("set wins busy", {31'd0, busy}, 32'd1);
    drive(1'b0, 16'h0000, 1'b1, 1'b1, 3'd6, 1'b0); step();
    check("clear busy", {31'd0, busy}, 32'd0);

    // Reset in the middle of a handshake
    drive(1'b1, 16'h0651, 1'b1, 1'b0, 3'd0, 1'b0); step();
    drive(1'b1, 16'h0261, 1'b1, 1'b0, 3'd0, 1'b0);
    rst_n = 1'b0;
    step();
    check("midrst out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst busy", {31'd0, busy}, 32'd0);
`ifdef DECODE_PERF_CNT_EN
    check("midrst stall", stall_cnt, 32'd0);
`endif
    rst_n = 1'b1;
    drive(1'b0, 16'h0000, 1'b1, 1'b0, 3'd0, 1'b0);
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net against a stuck run
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
